// File: rtl/shift_mix_stage.sv
// shift_mix_stage: registered AES ShiftRows + MixColumns round stage.
// Takes a SubBytes state and delivers the transformed state over valid/ready.
// A main output register plus one skid entry absorbs a single-cycle stall.
// i_last selects the final-round path, where MixColumns is skipped.
//
// Ports:
//   i_clock, i_reset_n       clock, async active-low reset
//   i_data/i_valid/i_last    upstream block (byte k = i_data[8k:8k+7], column-major)
//   o_ready                  stage can accept a block (registered, = !skid_valid)
//   o_data/o_valid/o_last    downstream block
//   i_ready                  downstream accepts this cycle
//   o_blocks                 wrapping count of blocks transferred out
module shift_mix_stage #(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic [0:127]           i_data,
  input  logic                   i_valid,
  input  logic                   i_last,
  output logic                   o_ready,
  output logic [0:127]           o_data,
  output logic                   o_valid,
  output logic                   o_last,
  input  logic                   i_ready,
  output logic [COUNT_WIDTH-1:0] o_blocks
);

  localparam int unsigned STATE_W = 128;

  // GF(2^8) multiply by x, reduced by the AES polynomial.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  logic [0:STATE_W-1] sr_w;
  logic [0:STATE_W-1] mc_w;
  logic [0:STATE_W-1] xform_w;

  // ShiftRows: row r of the output takes column (c+r) mod 4 of the input.
  for (genvar r = 0; r < 4; r++) begin : g_sr_row
    for (genvar c = 0; c < 4; c++) begin : g_sr_col
      assign sr_w[8*(r+4*c) +: 8] = i_data[8*(r+4*((c+r)%4)) +: 8];
    end
  end

  // MixColumns on each column of the ShiftRows result.
  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr_w[32*c      +: 8];
    assign a1 = sr_w[32*c + 8  +: 8];
    assign a2 = sr_w[32*c + 16 +: 8];
    assign a3 = sr_w[32*c + 24 +: 8];
    assign mc_w[32*c      +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    assign mc_w[32*c + 8  +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    assign mc_w[32*c + 16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    assign mc_w[32*c + 24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
  end

  // Final round bypasses MixColumns.
  assign xform_w = i_last ? sr_w : mc_w;

  logic [0:STATE_W-1]     out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   out_valid_q, out_valid_d;
  logic [0:STATE_W-1]     skid_data_q, skid_data_d;
  logic                   skid_last_q, skid_last_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [COUNT_WIDTH-1:0] blocks_q, blocks_d;
  logic                   accept_c;
  logic                   drain_c;

  assign accept_c = i_valid & ~skid_valid_q;
  assign drain_c  = out_valid_q & i_ready;

  // Next-state for output register, skid entry and transfer counter.
  always_comb begin
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_valid_d = skid_valid_q;
    blocks_d     = blocks_q;

    if (skid_valid_q) begin
      // Skid full: upstream is stalled, only a drain moves anything.
      if (drain_c) begin
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (accept_c && (!out_valid_q || drain_c)) begin
      out_data_d  = xform_w;
      out_last_d  = i_last;
      out_valid_d = 1'b1;
    end else if (accept_c) begin
      // Output stalled: park the new block in the skid entry.
      skid_data_d  = xform_w;
      skid_last_d  = i_last;
      skid_valid_d = 1'b1;
    end else if (drain_c) begin
      out_valid_d = 1'b0;
    end

    if (drain_c) begin
      blocks_d = blocks_q + COUNT_WIDTH'(1);
    end
  end

  // State registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      blocks_q     <= '0;
    end else begin
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_valid_q <= skid_valid_d;
      blocks_q     <= blocks_d;
    end
  end

  assign o_ready  = ~skid_valid_q;
  assign o_data   = out_data_q;
  assign o_last   = out_last_q;
  assign o_valid  = out_valid_q;
  assign o_blocks = blocks_q;

endmodule

// File: tb/tb_shift_mix_stage.sv
// Testbench for shift_mix_stage: scoreboard of expected blocks pushed on
// accept and popped on drain, plus directed FIPS-197, stall/skid, reset and
// counter-wrap checks. A second instance with a 4-bit counter shares stimulus.
module tb_shift_mix_stage;

  logic         clk;
  logic         rst_n;
  logic [0:127] din;
  logic         vld;
  logic         lst;
  logic         rdy;
  logic         o_ready;
  logic [0:127] o_data;
  logic         o_valid;
  logic         o_last;
  logic [15:0]  o_blocks;
  logic         o_ready_w4;
  logic [0:127] o_data_w4;
  logic         o_valid_w4;
  logic         o_last_w4;
  logic [3:0]   o_blocks_w4;

  int vectors_applied = 0;
  int miscompares     = 0;

  logic [128:0] exp_q[$];   // {last, data}
  int           model_blocks = 0;

  shift_mix_stage u_dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .i_data   (din),
    .i_valid  (vld),
    .i_last   (lst),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_last   (o_last),
    .i_ready  (rdy),
    .o_blocks (o_blocks)
  );

  shift_mix_stage #(.COUNT_WIDTH(4)) u_dut_w4 (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .i_data   (din),
    .i_valid  (vld),
    .i_last   (lst),
    .o_ready  (o_ready_w4),
    .o_data   (o_data_w4),
    .o_valid  (o_valid_w4),
    .o_last   (o_last_w4),
    .i_ready  (rdy),
    .o_blocks (o_blocks_w4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors_applied++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input int k);
    logic [7:0] a2;
    a2 = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    case (k)
      1:       return a;
      2:       return a2;
      default: return a2 ^ a;
    endcase
  endfunction

  // Reference round transform built from a row/column state matrix.
  function automatic logic [0:127] model(input logic [0:127] d, input logic last);
    logic [7:0]   st[4][4];
    logic [7:0]   sr[4][4];
    logic [7:0]   acc;
    logic [0:127] res;
    int           coef[4];
    coef = '{2, 3, 1, 1};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = d[8*(r+4*c) +: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sr[r][c] = st[r][(c+r)%4];
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        if (last) begin
          acc = sr[i][c];
        end else begin
          acc = 8'h00;
          for (int j = 0; j < 4; j++)
            acc = acc ^ gmul(sr[j][c], coef[(j-i+4)%4]);
        end
        res[8*(i+4*c) +: 8] = acc;
      end
    return res;
  endfunction

  // Scoreboard monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    logic [128:0] e;
    if (!rst_n) begin
      exp_q.delete();
      model_blocks = 0;
    end else begin
      check_eq("blocks", 128'(o_blocks), 128'(model_blocks % 65536));
      check_eq("blocks_w4", 128'(o_blocks_w4), 128'(model_blocks % 16));
      check_eq("valid_vs_occupancy", 128'(o_valid), 128'(exp_q.size() > 0));
      check_eq("ready_vs_occupancy", 128'(o_ready), 128'(exp_q.size() < 2));
      if (o_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_output", 128'(o_valid), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_data", o_data, e[127:0]);
          check_eq("sb_last", 128'(o_last), 128'(e[128]));
        end
        model_blocks++;
      end
      if (vld && o_ready)
        exp_q.push_back({lst, model(din, lst)});
    end
  end

  task automatic drive(input logic v, input logic [0:127] d, input logic l, input logic r);
    vld = v;
    din = d;
    lst = l;
    rdy = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [0:127] FIPS_IN   = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [0:127] FIPS_MC   = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [0:127] FIPS_LAST = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  initial begin
    logic [0:127] blk_a, blk_b, blk_c, rnd;
    logic         rl;

    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    step();
    check_eq("rst_valid", 128'(o_valid), 128'(0));
    check_eq("rst_ready", 128'(o_ready), 128'(1));
    check_eq("rst_data", o_data, 128'(0));
    check_eq("rst_last", 128'(o_last), 128'(0));
    check_eq("rst_blocks", 128'(o_blocks), 128'(0));
    rst_n = 1'b1;
    step();

    // FIPS-197 round 1, MixColumns applied.
    drive(1'b1, FIPS_IN, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, 1'b1);
    check_eq("fips_valid", 128'(o_valid), 128'(1));
    check_eq("fips_data", o_data, FIPS_MC);
    check_eq("fips_last", 128'(o_last), 128'(0));
    step();
    check_eq("fips_blocks", 128'(o_blocks), 128'(1));
    check_eq("fips_drained", 128'(o_valid), 128'(0));

    // Final round, MixColumns skipped.
    drive(1'b1, FIPS_IN, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, 1'b1);
    check_eq("last_data", o_data, FIPS_LAST);
    check_eq("last_flag", 128'(o_last), 128'(1));
    step();
    check_eq("last_blocks", 128'(o_blocks), 128'(2));

    // Stall and skid: A held, B into skid, C waits, then all drain in order.
    blk_a = {$urandom, $urandom, $urandom, $urandom};
    blk_b = {$urandom, $urandom, $urandom, $urandom};
    blk_c = {$urandom, $urandom, $urandom, $urandom};
    drive(1'b1, blk_a, 1'b0, 1'b0);
    step();
    check_eq("stall_a_out", o_data, model(blk_a, 1'b0));
    check_eq("stall_ready1", 128'(o_ready), 128'(1));
    drive(1'b1, blk_b, 1'b1, 1'b0);
    step();
    check_eq("skid_ready0", 128'(o_ready), 128'(0));
    check_eq("stall_hold1", o_data, model(blk_a, 1'b0));
    drive(1'b1, blk_c, 1'b0, 1'b0);
    step();
    check_eq("skid_ready0b", 128'(o_ready), 128'(0));
    check_eq("stall_hold2", o_data, model(blk_a, 1'b0));
    check_eq("stall_hold_valid", 128'(o_valid), 128'(1));
    rdy = 1'b1;
    step();
    check_eq("skid_to_out", o_data, model(blk_b, 1'b1));
    check_eq("skid_last", 128'(o_last), 128'(1));
    check_eq("ready_back", 128'(o_ready), 128'(1));
    step();
    drive(1'b0, '0, 1'b0, 1'b1);
    check_eq("c_out", o_data, model(blk_c, 1'b0));
    step();
    step();
    check_eq("stall_blocks", 128'(o_blocks), 128'(5));

    // Mid-stream reset with both entries full: everything discarded.
    drive(1'b1, blk_a, 1'b0, 1'b0);
    step();
    drive(1'b1, blk_b, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    check_eq("full_before_rst", 128'(o_ready), 128'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_valid", 128'(o_valid), 128'(0));
    check_eq("mrst_ready", 128'(o_ready), 128'(1));
    check_eq("mrst_blocks", 128'(o_blocks), 128'(0));
    check_eq("mrst_data", o_data, 128'(0));
    step();
    rst_n = 1'b1;
    rdy = 1'b1;
    step();
    step();
    step();
    check_eq("mrst_no_output", 128'(o_valid), 128'(0));

    // Full-rate stream of 20 random blocks.
    for (int i = 0; i < 20; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      rl  = 1'($urandom_range(0, 1));
      drive(1'b1, rnd, rl, 1'b1);
      check_eq("stream_ready", 128'(o_ready), 128'(1));
      if (o_blocks == 16'd17)
        check_eq("wrap17", 128'(o_blocks_w4), 128'(1));
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
    step();
    check_eq("stream_blocks", 128'(o_blocks), 128'(20));
    check_eq("stream_blocks_w4", 128'(o_blocks_w4), 128'(4));
    check_eq("sb_empty", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_mix_stage.md
# shift_mix_stage

Registered AES round stage combining ShiftRows and MixColumns. It sits directly downstream of the SubBytes stage and consumes its 128-bit state. It delivers the transformed state to the AddRoundKey stage through a valid/ready handshake. A two-entry output buffer (main plus skid) lets upstream keep streaming when downstream stalls for one cycle. A per-block last-round flag skips MixColumns, as AES requires for the final round.

## Interface
- COUNT_WIDTH, 16, width of the completed-block counter o_blocks.
- i_clock  in  1  sole clock; all state updates on the rising edge.
- i_reset_n  in  1  reset, asynchronous assert, active-low.
- i_data  in  [0:127]  SubBytes output state; byte k = i_data[8k:8k+7]; byte index = row + 4*col (column-major).
- i_valid  in  1  i_data/i_last valid this cycle.
- i_last  in  1  final AES round; skip MixColumns for this block.
- o_ready  out  1  stage can accept a block this cycle.
- o_data  out  [0:127]  transformed state, same byte ordering as i_data.
- o_valid  out  1  o_data/o_last valid.
- o_last  out  1  i_last carried with the block.
- i_ready  in  1  downstream accepts o_data this cycle.
- o_blocks  out  COUNT_WIDTH  count of blocks transferred out; wraps modulo 2^COUNT_WIDTH.

## Operation
- ShiftRows: s[r+4c] = in[r + 4*((c+r) mod 4)], r,c in 0..3. Row 0 is unshifted; row r rotates left by r.
- MixColumns (i_last=0): for column bytes a0..a3, each output is computed as follows. xt(a) = {a[1:7],0} ^ (a MSB ? 8'h1b : 0). All arithmetic is GF(2^8), 8-bit, with no carries.
  - b0 = xt(a0)^xt(a1)^a1^a2^a3
  - b1 = a0^xt(a1)^xt(a2)^a2^a3
  - b2 = a0^a1^xt(a2)^xt(a3)^a3
  - b3 = xt(a0)^a0^a1^a2^xt(a3)
- i_last=1: the result is the ShiftRows output unchanged.
- The transform is combinational on i_data and is captured only when accepted.
- Accept = i_valid & o_ready. Drain = o_valid & i_ready.
- o_ready is registered and equals !skid_valid.
- Internal state:
  - Output register: o_data, o_last, o_valid.
  - Skid register: skid_data, skid_last, skid_valid.
- Next-state rules, priority as listed:
  - skid_valid=1 & Drain: output ← skid, skid_valid ← 0. No accept is possible, since o_ready=0.
  - skid_valid=1 & !Drain: hold everything.
  - skid_valid=0 & Accept & (!o_valid | Drain): output ← f(i_data), o_valid ← 1.
  - skid_valid=0 & Accept & o_valid & !Drain: skid ← f(i_data), skid_valid ← 1; output holds.
  - skid_valid=0 & !Accept & Drain: o_valid ← 0. o_data keeps its last value.
- o_blocks increments by 1 on every Drain and wraps from all-ones to 0.
- Block order is strictly FIFO. No block is dropped or duplicated.
- i_data and i_last are ignored when Accept=0.

## Timing
- Reset (i_reset_n=0, effective immediately):
  - o_valid=0, skid_valid=0, o_ready=1
  - o_data=0, o_last=0, o_blocks=0
- Reset mid-operation discards both buffered blocks with no output transfer.
- Latency: a block accepted at edge N is presented with o_valid=1 after edge N (visible in cycle N+1), if the output register is free or draining.
- Throughput: 1 block/cycle sustained while i_ready=1.
- On a downstream stall, the output holds stable: o_data, o_last and o_valid do not change while o_valid=1 & i_ready=0.
- Stall with output full and skid empty: one more block is accepted into skid, and o_ready drops after that edge.
- Stall release with skid full: the skid block moves to the output on the Drain edge. o_ready returns to 1 the cycle after.
- Simultaneous Accept and Drain with skid empty: the new block replaces the output register, and the skid stays empty.
- Back-to-back i_last values are tracked independently per block.

## Test plan
- Reset check:
  - Stimulus: assert i_reset_n=0 mid-stream with both entries full.
  - Response: o_valid=0, o_ready=1, o_blocks=0 immediately, and no later output of the discarded blocks.
- FIPS-197 round 1:
  - Stimulus: i_data = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30, i_last=0, i_ready=1.
  - Response: o_data = 04 66 81 e5 e0 cb 19 9a 48 f8 d3 7a 28 06 26 4c, o_valid one cycle later, o_blocks=1.
- Last round:
  - Stimulus: the same input with i_last=1.
  - Response: o_data = d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5, o_last=1.
- Stall and skid:
  - Stimulus: stream blocks A, B, C with i_ready=0 for 3 cycles, then 1.
  - Response: A held on the output. B accepted into skid. o_ready=0 until skid drains. Outputs appear in order A, B, C with none lost.
- Full-rate stream:
  - Stimulus: 20 random blocks with random i_last, i_valid=1, i_ready=1.
  - Response: outputs match a software model one cycle later, o_ready stays 1, o_blocks=20.
- Counter wrap:
  - Stimulus: COUNT_WIDTH=4, 17 transfers.
  - Response: o_blocks=1 after the 17th Drain.
